// File: rtl/multi_duty_clk_gen_pkg.sv
// multi_duty_clk_gen_pkg: shared states, defaults and phase clamp helper
package multi_duty_clk_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int DEF_NCH = 4;
  localparam int DEF_CW = 8;
  function automatic logic [31:0] clamp_phase(input logic [31:0] phase, input logic [31:0] period);
    return (phase >= period) ? 32'd0 : phase;
  endfunction
endpackage

// File: rtl/duty_clk_channel.sv
// duty_clk_channel: one programmable clock/PWM channel with glitch-free start/stop
module duty_clk_channel
  import multi_duty_clk_gen_pkg::*;
#(
  parameter int   CW       = DEF_CW,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          sync,
  input  logic [CW-1:0] period,
  input  logic [CW-1:0] high_cnt,
  input  logic [CW-1:0] phase,
  output logic          clk_out,
  output logic          active,
  output logic          wrap
);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, per_sh, per_nx, hi_sh, hi_nx, start;
  logic at_end, load, wrap_nx, out_nx;
  assign start = CW'(clamp_phase(32'(phase), 32'(period)));
  assign active = state != IDLE;
  always_comb begin
    at_end = active && per_sh != '0 && cnt == per_sh - CW'(1);
    load = enable && !active || active && sync;
    wrap_nx = at_end && !sync;
    state_nx = !active ? (enable ? RUN : IDLE) : enable ? RUN : wrap_nx ? IDLE : DRAIN;
    cnt_nx = load ? start : wrap_nx ? '0 : (!active || per_sh == '0) ? cnt : cnt + CW'(1);
    // shadows only move at a period boundary, so mid-period edits never make runt pulses
    per_nx = (load || wrap_nx && enable) ? period : per_sh;
    hi_nx = (load || wrap_nx && enable) ? high_cnt : hi_sh;
    out_nx = (state_nx == IDLE || per_nx == '0) ? IDLE_LVL : cnt_nx < hi_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      per_sh <= '0;
      hi_sh <= '0;
      clk_out <= IDLE_LVL;
      wrap <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      per_sh <= per_nx;
      hi_sh <= hi_nx;
      clk_out <= out_nx;
      wrap <= wrap_nx;
    end
  end
endmodule

// File: rtl/multi_duty_clk_gen.sv
// multi_duty_clk_gen: NCH independent programmable clock/PWM channels sharing a sync
module multi_duty_clk_gen
  import multi_duty_clk_gen_pkg::*;
#(
  parameter int   NCH      = DEF_NCH,
  parameter int   CW       = DEF_CW,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    enable,
  input  logic [NCH*CW-1:0] period,
  input  logic [NCH*CW-1:0] high_cnt,
  input  logic [NCH*CW-1:0] phase,
  input  logic              sync,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    active,
  output logic [NCH-1:0]    wrap
);
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    duty_clk_channel #(.CW(CW), .IDLE_LVL(IDLE_LVL)) u_ch (
      .clk(clk),
      .rst(rst),
      .enable(enable[i]),
      .sync(sync),
      .period(period[i*CW +: CW]),
      .high_cnt(high_cnt[i*CW +: CW]),
      .phase(phase[i*CW +: CW]),
      .clk_out(clk_out[i]),
      .active(active[i]),
      .wrap(wrap[i])
    );
  end
endmodule

// File: tb/tb_multi_duty_clk_gen.sv
// tb_multi_duty_clk_gen: scoreboard bench against a per-channel cycle model
module tb_multi_duty_clk_gen;
  localparam int NCH = 4;
  localparam int CW = 8;
  localparam logic IDLE_LVL = 1'b0;
  logic clk = 1'b0;
  logic rst, sync;
  logic [NCH-1:0] enable, clk_out, active, wrap;
  logic [NCH*CW-1:0] period, high_cnt, phase;
  multi_duty_clk_gen #(.NCH(NCH), .CW(CW), .IDLE_LVL(IDLE_LVL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .high_cnt(high_cnt),
    .phase(phase), .sync(sync), .clk_out(clk_out), .active(active), .wrap(wrap)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [NCH-1:0] o, a, w;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0;
  bit on[NCH];
  int pos[NCH], pp[NCH], hh[NCH];
  // one clock of every channel: a running channel walks pos 0..P-1 and only
  // adopts new P/H at a start, a sync, or a boundary where it keeps running
  task automatic model_step();
    exp_t e;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      int pe, he, fe, st;
      pe = int'(period[c*CW +: CW]);
      he = int'(high_cnt[c*CW +: CW]);
      fe = int'(phase[c*CW +: CW]);
      st = (fe >= pe) ? 0 : fe;
      if (rst) begin
        on[c] = 0; pos[c] = 0; pp[c] = 0; hh[c] = 0;
      end else if (!on[c]) begin
        if (enable[c]) begin on[c] = 1; pp[c] = pe; hh[c] = he; pos[c] = st; end
      end else if (sync) begin
        pp[c] = pe; hh[c] = he; pos[c] = st;
      end else if (pp[c] != 0) begin
        if (pos[c] == pp[c] - 1) begin
          e.w[c] = 1'b1;
          pos[c] = 0;
          if (enable[c]) begin pp[c] = pe; hh[c] = he; end
          else on[c] = 0;
        end else pos[c]++;
      end
      e.a[c] = on[c];
      e.o[c] = (on[c] && pp[c] != 0) ? (pos[c] < hh[c]) : IDLE_LVL;
    end
    q.push_back(e);
  endtask
  task automatic cyc(int n);
    repeat (n) begin
      model_step();
      @(negedge clk);
    end
  endtask
  task automatic cfg(int c, int p, int h, int f);
    period[c*CW +: CW] = CW'(p);
    high_cnt[c*CW +: CW] = CW'(h);
    phase[c*CW +: CW] = CW'(f);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        vectors++;
        if (clk_out !== e.o) begin
          miscompares++;
          $display("FAIL clk_out t=%0t got %b expected %b", $time, clk_out, e.o);
        end
        if (wrap !== e.w) begin
          miscompares++;
          $display("FAIL wrap t=%0t got %b expected %b", $time, wrap, e.w);
        end
        if (active !== e.a) begin
          miscompares++;
          $display("FAIL active t=%0t got %b expected %b", $time, active, e.a);
        end
      end
    end
  end
  initial begin
    rst = 1'b1; sync = 1'b0; enable = '0; period = '0; high_cnt = '0; phase = '0;
    cyc(2);
    rst = 1'b0;
    cfg(0, 10, 6, 0);
    enable[0] = 1'b1;
    cyc(25);
    rst = 1'b1;
    cyc(3);
    rst = 1'b0; enable = '0;
    cyc(2);
    cfg(0, 8, 4, 0); cfg(1, 8, 4, 4);
    enable = 4'b0011;
    cyc(13);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0;
    cyc(12);
    enable = '0;
    cyc(12);
    cfg(0, 10, 6, 0);
    enable[0] = 1'b1;
    cyc(13);
    enable[0] = 1'b0;
    cyc(15);
    enable[0] = 1'b1;
    cyc(3);
    cfg(0, 10, 2, 0);
    cyc(25);
    enable = '0;
    cyc(12);
    cfg(0, 0, 3, 0); cfg(1, 10, 0, 0); cfg(2, 10, 12, 0); cfg(3, 1, 1, 0);
    enable = '1;
    cyc(20);
    enable = '0;
    cyc(5);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) cfg(c, $urandom_range(1, 12), $urandom_range(0, 14), $urandom_range(0, 14));
    for (int k = 0; k < 10 * NCH; k++) begin
      int c;
      c = $urandom_range(0, NCH - 1);
      enable[c] = ~enable[c];
      if ($urandom_range(0, 3) == 0)
        cfg(c, $urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 14));
      if ($urandom_range(0, 5) == 0) begin
        sync = 1'b1;
        cyc(1);
        sync = 1'b0;
      end
      cyc($urandom_range(1, 255));
    end
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/multi_duty_clk_gen.md
Name: multi_duty_clk_gen

Overview:
- Synthesizable, N-channel, programmable clock/PWM generator, derived from the system clock.
- Each channel has a runtime-programmable period, high time and phase offset.
- Each channel has its own enable, with glitch-free start and stop.
- Feeds test clocks and enable strobes to downstream blocks; replaces the fixed-DUTY behavioural clock model.

Parameters:
- NCH, 4, number of independent output channels (1..16).
- CW, 8, counter/config width in bits; max period 2^CW-1 cycles.
- IDLE_LVL, 0, output level of a channel that is idle or stopped.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- enable  input  NCH  per-channel run request; level-sensitive.
- period  input  NCH*CW  per-channel period in clk cycles; channel i uses slice [i*CW +: CW].
- high_cnt  input  NCH*CW  per-channel high time in cycles.
- phase  input  NCH*CW  per-channel start count (phase offset).
- sync  input  1  single-cycle pulse; realigns all running channels.
- clk_out  output  NCH  generated waveforms, registered.
- active  output  NCH  channel is in RUN or DRAIN.
- wrap  output  NCH  one-cycle pulse when a channel counter wraps to 0.

Behaviour:
- Reset values: clk_out = {NCH{IDLE_LVL}}, active = 0, wrap = 0, every counter = 0, every state = IDLE, every shadow register = 0.
- Per-channel FSM:
  - IDLE -> RUN: on enable[i]=1. The same edge loads shadow period/high from the inputs and sets cnt = phase. If phase >= period, cnt = 0.
  - RUN -> DRAIN: on enable[i]=0. The current period completes.
  - DRAIN -> RUN: on enable[i]=1 before the wrap. There is no restart and no phase reload.
  - DRAIN -> IDLE: on the wrap edge. clk_out takes IDLE_LVL at that edge.
- Counter (RUN/DRAIN):
  - If cnt == period_sh-1, cnt <= 0, wrap pulses for 1 cycle, and shadows reload from the inputs (RUN only).
  - Otherwise cnt <= cnt+1.
- Output: clk_out[i] <= (cnt_next < high_sh) while in RUN/DRAIN. The output register tracks the counter with no extra lag.
- Latency: enable seen at edge N -> clk_out valid from edge N.
  - Example: phase=0, high>0 -> clk_out high immediately after edge N.
- Config changes mid-period take effect only at the wrap, so no runt pulses.
- Degenerate config (evaluated on shadow values):
  - period_sh=0: channel held at IDLE_LVL. wrap never pulses. active still asserted.
  - high_sh=0: output constant low.
  - high_sh >= period_sh: output constant high.
  - period_sh=1: wrap pulses every cycle.
- sync=1: every channel in RUN/DRAIN loads cnt = phase (clamped as above) and reloads its shadows. No wrap pulse is generated.
- Simultaneous sync and enable rise: treated as a normal start.
- Simultaneous sync and wrap: sync wins.
- Channels are fully independent apart from the shared sync.
- rst mid-operation returns everything to reset values on that edge. rst has priority over all inputs.
- Arithmetic: unsigned CW-bit values throughout. The counter never exceeds period_sh-1, so there is no overflow.

Decomposition:
- Package multi_duty_clk_gen_pkg:
  - State enum {IDLE, RUN, DRAIN} (2-bit).
  - Default CW/NCH localparams.
  - A function clamp_phase(phase, period).
- Sub-module duty_clk_channel: one channel with its FSM, counter, shadows and output register.
- The top module generate-loops NCH instances and slices the flattened config buses.

Test Plan:
- Reset: assert rst for 3 cycles during activity -> clk_out=0, active=0, wrap=0 on the following edge.
- Basic 60% duty: ch0 period=10, high=6, phase=0, enable=1 -> clk_out high 6 / low 4 cycles repeating; wrap every 10th cycle; first high at enable edge.
- Phase offset: ch0/ch1 period=8, high=4, phases 0/4, enabled same cycle -> ch1 exactly 180 deg shifted; sync pulse mid-run realigns both to the same relationship.
- Glitch-free stop and config change:
  - Deassert enable at cnt=3 of period=10 -> output completes the period, goes idle at wrap, active drops then.
  - Change high 6->2 mid-period -> new duty starts only after the next wrap.
- Degenerate configs: period=0 -> clk_out stays 0; high=0 -> constant 0; high=12 with period=10 -> constant 1; period=1 -> wrap every cycle.
- Random enable toggling (random 8-bit delays, 10 toggles, all channels) -> scoreboard model matches clk_out/wrap every cycle; no high or low pulse shorter than the configured widths, except a truncated stop never occurs.
